sync_fifo_param: RTL

Single-clock, parametrised FIFO for buffering data between same-clock pipeline stages. It is the in-fabric successor to the dual-clock vendor FIFO wrapper. It adds configurable width and depth, programmable almost-full and almost-empty thresholds, and selectable standard or first-word-fall-through (FWFT) read mode. It also exposes an exact occupancy count and registered overflow/underflow error pulses.

---
 rtl/sync_fifo_param.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with programmable almost flags, exact occupancy,
// registered overflow/underflow pulses and selectable standard or FWFT read mode.
module sync_fifo_param #(
    parameter int DW     = 8,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DW-1:0]              din,
    input  logic                       rd_en,
    output logic [DW-1:0]              dout,
    output logic                       valid,
    output logic                       full,
    output logic                       almost_full,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     data_count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW:0] AF_CNT   = CW'(AF_LVL);
    localparam logic [AW:0] AE_CNT   = CW'(AE_LVL);

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic full_w, empty_w, wr_acc, rd_acc;

    // Flags come only from the registered count, never from this cycle's requests.
    assign full_w  = (count_q == FULL_CNT);
    assign empty_w = (count_q == '0);
    assign wr_acc  = wr_en & ~full_w;
    assign rd_acc  = rd_en & ~empty_w;

    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign data_count   = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = wr_en & full_w;
        underflow_d = rd_en & empty_w;

        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array has no reset; stale words are never visible because
    // only positions between rd_ptr and wr_ptr are ever read out.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) mem_q[wr_ptr_q] <= din;
    end

    if (FWFT == 0) begin : g_std
        logic [DW-1:0] dout_q, dout_d;
        logic          valid_q, valid_d;

        always_comb begin
            dout_d  = dout_q;
            valid_d = rd_acc;
            if (rd_acc) dout_d = mem_q[rd_ptr_q];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                dout_q  <= dout_d;
                valid_q <= valid_d;
            end
        end

        assign dout  = dout_q;
        assign valid = valid_q;
    end else begin : g_fwft
        // Head word shown directly; forced to zero while empty so reset yields dout=0.
        assign valid = ~empty_w;
        assign dout  = empty_w ? '0 : mem_q[rd_ptr_q];
    end

endmodule
